vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
- Generates the 640x480@60 Hz raster timing consumed by the game renderer.
- Divides the 50 MHz system clock into a pixel-enable strobe and maintains the horizontal and vertical counters.
- Drives pix_x/pix_y/video_on to the graphics block and hsync/vsync to the VGA connector.
- Emits line and frame strobes so game logic can step once per frame instead of free-running counters.

Parameters:
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=1)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_on  out  1  high while (pix_x, pix_y) is in the visible area
- p_tick  out  1  one-clk pulse per pixel period
- pix_x  out  10  current horizontal count, 0..H_TOT-1
- pix_y  out  10  current vertical count, 0..V_TOT-1
- line_tick  out  1  one-clk pulse on the last pixel of each line
- frame_tick  out  1  one-clk pulse on the last pixel of each frame

Behaviour:
- Clocking and reset:
  - Only clk is used as a clock; all state updates on posedge clk.
  - reset is synchronous and active-high, and it wins over every other event.
- Derived totals: H_TOT = H_DISP+H_FP+H_SYNC+H_BP (800); V_TOT = V_DISP+V_FP+V_SYNC+V_BP (525).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt == CLK_DIV-1), decoded combinationally from the register.
  - With CLK_DIV=1, p_tick is high on every cycle out of reset.
- Horizontal counter (h_cnt): advances only in cycles where p_tick=1; wraps H_TOT-1 -> 0.
- Vertical counter (v_cnt): advances only when p_tick=1 and h_cnt=H_TOT-1; wraps V_TOT-1 -> 0.
- pix_x = h_cnt and pix_y = v_cnt, both taken directly from the registers with zero latency.
- video_on = (h_cnt < H_DISP) && (v_cnt < V_DISP), decoded from the same registers, so it is coherent with pix_x/pix_y in the same cycle.
- Sync outputs:
  - hsync and vsync are registers, computed from the next-state counter values.
  - Consequence: they change in the same cycle the counters do, with no skew against pix_x/pix_y.
  - hsync = 0 iff H_DISP+H_FP <= h_cnt <= H_DISP+H_FP+H_SYNC-1 (656..751).
  - vsync = 0 iff V_DISP+V_FP <= v_cnt <= V_DISP+V_FP+V_SYNC-1 (490..491).
- line_tick = p_tick && h_cnt==H_TOT-1.
- frame_tick = line_tick && v_cnt==V_TOT-1. It is exactly 1 clk wide, once per H_TOT*V_TOT*CLK_DIV clocks (840000 at defaults).
- Reset values:
  - div_cnt=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1.
  - Hence pix_x=0, pix_y=0, video_on=1, p_tick=0 (1 if CLK_DIV=1), line_tick=0, frame_tick=0.
- Reset asserted mid-frame: the next cycle shows the reset values above. Timing restarts from (0,0) with the full CLK_DIV-cycle divider phase; no partial sync pulse is carried over.
- Widths: 10-bit counters cover H_TOT and V_TOT up to 1023. Parameter sets exceeding that are illegal and need no handling.
- No combinational path from any input to any output except through registers.

Test Plan:
- Reset → all reset values hold during and one cycle after reset. First p_tick arrives at clock 2 after deassertion (CLK_DIV=2); pix_x becomes 1 in the following cycle.
- Free run one line → line_tick period = 1600 clks. hsync low for exactly 192 clks, starting the cycle pix_x becomes 656 and ending when pix_x becomes 752. video_on low for pix_x 640..799.
- Free run one frame → frame_tick period = 840000 clks, coinciding with pix_x=799, pix_y=524, p_tick=1. vsync low for exactly 2 lines (3200 clks) at pix_y 490..491. video_on=0 throughout pix_y 480..524.
- Reset at pix_x=700, pix_y=491 (hsync and vsync both low) → next cycle hsync=1, vsync=1, pix_x=0, pix_y=0, and no frame_tick is generated.
- CLK_DIV=1 build → p_tick constantly high and frame_tick period = 420000 clks. Sync windows are the same in pixel counts.
- Coherence check over a full frame: video_on == (pix_x<640 && pix_y<480) every cycle. pix_x never exceeds 799 and pix_y never exceeds 524.

Source files
------------

// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing: pixel-enable divider, h/v counters, registered syncs
// and line/frame strobes for the renderer and game logic.
module vga_sync_gen #(
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_tick,
    output logic       frame_tick
);
    localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_MAX    = 10'(H_TOT - 1);
    localparam logic [9:0]       V_MAX    = 10'(V_TOT - 1);
    localparam logic [9:0]       H_VIS    = 10'(H_DISP);
    localparam logic [9:0]       V_VIS    = 10'(V_DISP);
    localparam logic [9:0]       HS_START = 10'(H_DISP + H_FP);
    localparam logic [9:0]       HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0]       VS_START = 10'(V_DISP + V_FP);
    localparam logic [9:0]       VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt, v_cnt;
    logic [9:0]       h_next, v_next;
    logic             h_end;

    assign p_tick = (div_cnt == DIV_MAX);
    assign h_end  = (h_cnt == H_MAX);

    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (p_tick) begin
            if (h_end) begin
                h_next = '0;
                v_next = (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
            end else begin
                h_next = h_cnt + 10'd1;
            end
        end
    end

    // Syncs are decoded from the next-state counters so they switch on the
    // same edge as pix_x/pix_y, with no one-cycle skew.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else begin
            div_cnt <= p_tick ? '0 : div_cnt + DIV_W'(1);
            h_cnt   <= h_next;
            v_cnt   <= v_next;
            hsync   <= !((h_next >= HS_START) && (h_next <= HS_END));
            vsync   <= !((v_next >= VS_START) && (v_next <= VS_END));
        end
    end

    assign pix_x      = h_cnt;
    assign pix_y      = v_cnt;
    assign video_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign line_tick  = p_tick && h_end;
    assign frame_tick = line_tick && (v_cnt == V_MAX);
endmodule
